// File: rtl/ula_pkg.sv
// ula_pkg: opcodes and FSM states shared by ula_seq and its shifter.
// Build option ULA_FLAGS_EN adds zero/carry flag outputs to ula_seq.
package ula_pkg;

  localparam int ULA_NOT = 0;
  localparam int ULA_AND = 1;
  localparam int ULA_OR  = 2;
  localparam int ULA_XOR = 3;
  localparam int ULA_ADD = 4;
  localparam int ULA_SUB = 5;
  localparam int ULA_SHL = 6;
  localparam int ULA_SHR = 7;

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
    S_SHIFT,
    S_DONE
  } state_t;

endpackage

// File: rtl/ula_shifter.sv
// ula_shifter: iterative logical shifter, one bit position per clock.
// Build option ULA_FLAGS_EN adds the last-bit-out port.
module ula_shifter #(
  parameter int BITS = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            dir,
  input  logic [BITS-1:0] a,
  input  logic [BITS-1:0] amt,
  output logic [BITS-1:0] work,
  output logic            done
`ifdef ULA_FLAGS_EN
  ,
  output logic            last
`endif
);

  localparam int CNT_W = $clog2(BITS + 1);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_ld;

  // Shift amounts at or beyond the width saturate to a full flush.
  always_comb begin
    cnt_ld = amt[CNT_W-1:0];
    if (amt >= BITS'(BITS))
      cnt_ld = CNT_W'(BITS);
  end

  assign done = (cnt == '0);

  // Load on start, then one position per cycle until the count drains.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      work <= '0;
      cnt  <= '0;
`ifdef ULA_FLAGS_EN
      last <= 1'b0;
`endif
    end else if (start) begin
      work <= a;
      cnt  <= cnt_ld;
`ifdef ULA_FLAGS_EN
      last <= 1'b0;
`endif
    end else if (!done) begin
      cnt  <= cnt - CNT_W'(1);
      work <= dir ? (work >> 1) : (work << 1);
`ifdef ULA_FLAGS_EN
      last <= dir ? work[0] : work[BITS-1];
`endif
    end
  end

endmodule

// File: rtl/ula_seq.sv
// ula_seq: sequential ULA with valid/ready handshakes on both sides.
// Build option ULA_FLAGS_EN adds zero_out/carry_out flag ports.
module ula_seq
  import ula_pkg::*;
#(
  parameter int BITS = 8,
  parameter int OP   = 8
) (
  input  logic            clk_in,
  input  logic            rst_n_in,
  input  logic            valid_in,
  output logic            ready_out,
  input  logic [OP-1:0]   op_in,
  input  logic [BITS-1:0] a_in,
  input  logic [BITS-1:0] b_in,
  output logic            valid_out,
  input  logic            ready_in,
  output logic [BITS-1:0] result_out
`ifdef ULA_FLAGS_EN
  ,
  output logic            zero_out,
  output logic            carry_out
`endif
);

  state_t state, next;

  logic [OP-1:0]   op_q;
  logic [BITS-1:0] a_q, b_q;
  logic [BITS-1:0] alu_res;
  logic [BITS-1:0] sh_work;
  logic            sh_done;
  logic            accept;
  logic            shift_op;
`ifdef ULA_FLAGS_EN
  logic            alu_c;
  logic            alu_z;
  logic            sh_last;
`endif

  assign accept   = valid_in && ready_out;
  assign shift_op = (op_in == OP'(ULA_SHL)) ||
                    (op_in == OP'(ULA_SHR));

  ula_shifter #(.BITS(BITS)) u_shifter (
    .clk   (clk_in),
    .rst_n (rst_n_in),
    .start (accept && shift_op),
    .dir   (op_in == OP'(ULA_SHR)),
    .a     (a_in),
    .amt   (b_in),
    .work  (sh_work),
    .done  (sh_done)
`ifdef ULA_FLAGS_EN
    ,
    .last  (sh_last)
`endif
  );

  // State register.
  always_ff @(posedge clk_in) begin
    if (!rst_n_in)
      state <= S_IDLE;
    else
      state <= next;
  end

  // Next-state and handshake outputs.
  always_comb begin
    next      = state;
    ready_out = 1'b0;
    valid_out = 1'b0;
    unique case (state)
      S_IDLE: begin
        ready_out = 1'b1;
        if (valid_in)
          next = shift_op ? S_SHIFT : S_EXEC;
      end
      S_EXEC:  next = S_DONE;
      S_SHIFT: if (sh_done) next = S_DONE;
      S_DONE: begin
        valid_out = 1'b1;
        if (ready_in)
          next = S_IDLE;
      end
      default: next = S_IDLE;
    endcase
  end

  // Operand capture on handshake.
  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      op_q <= '0;
      a_q  <= '0;
      b_q  <= '0;
    end else if (accept) begin
      op_q <= op_in;
      a_q  <= a_in;
      b_q  <= b_in;
    end
  end

  // Single-cycle ops; reserved codes give zero with clear flags.
  always_comb begin
    alu_res = '0;
`ifdef ULA_FLAGS_EN
    alu_c   = 1'b0;
    alu_z   = 1'b0;
`endif
    case (op_q)
      OP'(ULA_NOT): alu_res = ~b_q;
      OP'(ULA_AND): alu_res = a_q & b_q;
      OP'(ULA_OR):  alu_res = a_q | b_q;
      OP'(ULA_XOR): alu_res = a_q ^ b_q;
`ifdef ULA_FLAGS_EN
      OP'(ULA_ADD): {alu_c, alu_res} = {1'b0, a_q} + {1'b0, b_q};
      OP'(ULA_SUB): {alu_c, alu_res} = {1'b0, a_q} - {1'b0, b_q};
`else
      OP'(ULA_ADD): alu_res = a_q + b_q;
      OP'(ULA_SUB): alu_res = a_q - b_q;
`endif
      default: alu_res = '0;
    endcase
`ifdef ULA_FLAGS_EN
    if (op_q < OP'(ULA_SHL))
      alu_z = (alu_res == '0);
`endif
  end

  // Result and flag registers, held through DONE.
  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      result_out <= '0;
`ifdef ULA_FLAGS_EN
      zero_out   <= 1'b0;
      carry_out  <= 1'b0;
`endif
    end else if (state == S_EXEC) begin
      result_out <= alu_res;
`ifdef ULA_FLAGS_EN
      zero_out   <= alu_z;
      carry_out  <= alu_c;
`endif
    end else if (state == S_SHIFT && sh_done) begin
      result_out <= sh_work;
`ifdef ULA_FLAGS_EN
      zero_out   <= (sh_work == '0);
      carry_out  <= sh_last;
`endif
    end
  end

endmodule

// File: tb/tb_ula_seq.sv
// tb_ula_seq: directed vector table plus corner sequences for ula_seq.
// Flag checks are enabled when ULA_FLAGS_EN is defined.
`timescale 1ns/1ps
module tb_ula_seq;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       valid_in = 1'b0;
  logic       ready_in = 1'b1;
  logic [7:0] op_in = '0;
  logic [7:0] a_in = '0;
  logic [7:0] b_in = '0;
  logic       ready_out;
  logic       valid_out;
  logic [7:0] result_out;
`ifdef ULA_FLAGS_EN
  logic       zero_out;
  logic       carry_out;
`endif

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ula_seq #(.BITS(8), .OP(8)) dut (
    .clk_in     (clk),
    .rst_n_in   (rst_n),
    .valid_in   (valid_in),
    .ready_out  (ready_out),
    .op_in      (op_in),
    .a_in       (a_in),
    .b_in       (b_in),
    .valid_out  (valid_out),
    .ready_in   (ready_in),
    .result_out (result_out)
`ifdef ULA_FLAGS_EN
    ,
    .zero_out   (zero_out),
    .carry_out  (carry_out)
`endif
  );

  typedef struct {
    logic [7:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] res;
    int         lat;
    logic       c;
    logic       z;
  } vec_t;

  vec_t vt[16];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic void model(input logic [7:0] op, a, b,
                                output logic [7:0] r, output int lat,
                                output logic c, output logic z);
    int k;
    k = (b > 8) ? 8 : int'(b);
    r = '0; c = 1'b0; lat = 1;
    case (op)
      8'd0: r = ~b;
      8'd1: r = a & b;
      8'd2: r = a | b;
      8'd3: r = a ^ b;
      8'd4: begin r = a + b; c = (int'(a) + int'(b)) > 255; end
      8'd5: begin r = a - b; c = (a < b); end
      8'd6: begin
        r = a << b; lat = 1 + k;
        c = (k == 0) ? 1'b0 : a[8-k];
      end
      8'd7: begin
        r = a >> b; lat = 1 + k;
        c = (k == 0) ? 1'b0 : a[k-1];
      end
      default: r = '0;
    endcase
    z = (op < 8) && (r == 0);
  endfunction

  task automatic run_op(input string name, input logic [7:0] op, a, b,
                        input logic [7:0] er, input int el,
                        input logic ec, input logic ez);
    int n;
    n = 0;
    while (!ready_out && n < 40) begin tick(); n++; end
    chk({name, " ready"}, ready_out, 1);
    op_in = op; a_in = a; b_in = b; valid_in = 1'b1;
    tick();
    valid_in = 1'b0;
    n = 0;
    while (!valid_out && n < 40) begin tick(); n++; end
    chk({name, " lat"}, n, el);
    chk({name, " res"}, result_out, er);
`ifdef ULA_FLAGS_EN
    chk({name, " carry"}, carry_out, ec);
    chk({name, " zero"}, zero_out, ez);
`endif
    tick();
    chk({name, " idle"}, {valid_out, ready_out}, 2'b01);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [7:0] r, a, b, op;
    int         lat;
    logic       c, z, seen;

    vt[0]  = '{8'd0, 8'h00, 8'h0F, 8'hF0, 1, 1'b0, 1'b0};
    vt[1]  = '{8'd1, 8'hF0, 8'h3C, 8'h30, 1, 1'b0, 1'b0};
    vt[2]  = '{8'd2, 8'hF0, 8'h0F, 8'hFF, 1, 1'b0, 1'b0};
    vt[3]  = '{8'd3, 8'h09, 8'h01, 8'h08, 1, 1'b0, 1'b0};
    vt[4]  = '{8'd4, 8'hFF, 8'h01, 8'h00, 1, 1'b1, 1'b1};
    vt[5]  = '{8'd4, 8'h12, 8'h34, 8'h46, 1, 1'b0, 1'b0};
    vt[6]  = '{8'd5, 8'h00, 8'h01, 8'hFF, 1, 1'b1, 1'b0};
    vt[7]  = '{8'd5, 8'h05, 8'h05, 8'h00, 1, 1'b0, 1'b1};
    vt[8]  = '{8'd6, 8'h81, 8'h03, 8'h08, 4, 1'b0, 1'b0};
    vt[9]  = '{8'd7, 8'h81, 8'h00, 8'h81, 1, 1'b0, 1'b0};
    vt[10] = '{8'd7, 8'hFF, 8'hFF, 8'h00, 9, 1'b1, 1'b1};
    vt[11] = '{8'd6, 8'h01, 8'h08, 8'h00, 9, 1'b1, 1'b1};
    vt[12] = '{8'd7, 8'h80, 8'h07, 8'h01, 8, 1'b0, 1'b0};
    vt[13] = '{8'd8, 8'h05, 8'h03, 8'h00, 1, 1'b0, 1'b0};
    vt[14] = '{8'hFF, 8'hAA, 8'h55, 8'h00, 1, 1'b0, 1'b0};
    vt[15] = '{8'd6, 8'h40, 8'h01, 8'h80, 2, 1'b0, 1'b0};

    tick(); tick();
    chk("reset ready", ready_out, 1);
    chk("reset valid", valid_out, 0);
    chk("reset result", result_out, 0);
`ifdef ULA_FLAGS_EN
    chk("reset flags", {zero_out, carry_out}, 2'b00);
`endif
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 16; i++)
      run_op($sformatf("vec%0d", i), vt[i].op, vt[i].a, vt[i].b,
             vt[i].res, vt[i].lat, vt[i].c, vt[i].z);

    // Abort a shift in flight with reset.
    run_op("pre_rst", 8'd2, 8'h3C, 8'hC3, 8'hFF, 1, 1'b0, 1'b0);
    op_in = 8'd6; a_in = 8'h01; b_in = 8'd5; valid_in = 1'b1;
    tick();
    valid_in = 1'b0;
    tick(); tick();
    rst_n = 1'b0;
    tick();
    chk("midrst valid", valid_out, 0);
    chk("midrst result", result_out, 8'h00);
    chk("midrst ready", ready_out, 1);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (valid_out) seen = 1'b1;
    end
    chk("midrst no result", seen, 0);

    // Backpressure: result held, new request ignored.
    ready_in = 1'b0;
    op_in = 8'd3; a_in = 8'hAA; b_in = 8'h55; valid_in = 1'b1;
    tick();
    valid_in = 1'b0;
    lat = 0;
    while (!valid_out && lat < 40) begin tick(); lat++; end
    chk("bp lat", lat, 1);
    op_in = 8'd4; a_in = 8'h01; b_in = 8'h01; valid_in = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk($sformatf("bp hold%0d", i),
          {valid_out, ready_out, result_out}, {1'b1, 1'b0, 8'hFF});
    end
    valid_in = 1'b0;
    ready_in = 1'b1;
    tick();
    chk("bp release", {valid_out, ready_out}, 2'b01);
    run_op("bp next", 8'd4, 8'h01, 8'h01, 8'h02, 1, 1'b0, 1'b0);

    // Shift sweep against the reference model.
    for (int i = 0; i < 48; i++) begin
      a = (i == 0) ? 8'h00 : (i == 1) ? 8'hFF : 8'($urandom);
      for (int s = 0; s < 10; s++) begin
        for (int d = 6; d < 8; d++) begin
          op = 8'(d);
          b = 8'(s);
          model(op, a, b, r, lat, c, z);
          run_op($sformatf("sw op%0d a%0h b%0d", d, a, s),
                 op, a, b, r, lat, c, z);
        end
      end
    end

    // Random ops including reserved codes.
    for (int i = 0; i < 300; i++) begin
      op = (i % 50 == 49) ? 8'($urandom) : 8'($urandom_range(0, 9));
      a = 8'($urandom);
      b = 8'($urandom);
      model(op, a, b, r, lat, c, z);
      run_op($sformatf("rnd%0d op%0h a%0h b%0h", i, op, a, b),
             op, a, b, r, lat, c, z);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
